data_mem_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: the single-cycle CPU's load/store path and a host port used by a loader or debugger.
- Sits between the CPU's ALU-result address, RD2 write data and mem-to-reg read path on one side, and the data RAM on the other.
- When the host wins a cycle, the CPU is stalled; the CPU top uses cpu_stall to hold the PC and suppress the register write.
- The host sees a grant/read-valid handshake. Fairness comes from a starvation limit and a bounded locked burst.

---
 rtl/data_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Data-RAM arbiter between the CPU load/store path and a host port (loader/debugger).
// Define ARB_STATS_EN to build the stall/grant statistics counters.
module data_mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             pc_rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wd,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_stall,
  input  logic             host_req,
  input  logic             host_we,
  input  logic             host_lock,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wd,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [DW-1:0]    host_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_wd,
  input  logic [DW-1:0]    ram_rd,
  output logic [CNT_W-1:0] stat_cpu_stalls,
  output logic [CNT_W-1:0] stat_host_grants
);

  localparam int unsigned WCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BCW = $clog2(BURST_MAX + 1);

  typedef enum logic {ST_CPU, ST_BURST} state_t;

  state_t          r_state;
  logic [WCW-1:0]  r_wait_cnt;
  logic [BCW-1:0]  r_burst_cnt;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata;

  logic            w_host_own;
  logic            w_cpu_own;
  logic            w_burst_last;

  // Owner selection; reset forces both grants off.
  always_comb begin
    w_host_own = 1'b0;
    w_cpu_own  = 1'b0;
    if (!pc_rst) begin
      if (r_state == ST_BURST) begin
        w_host_own = host_req;
      end else begin
        w_host_own = host_req && (!cpu_req || (r_wait_cnt == WCW'(STARVE_LIMIT)));
      end
      w_cpu_own = cpu_req && !w_host_own;
    end
  end

  assign w_burst_last = (r_burst_cnt == BCW'(BURST_MAX - 1));

  // RAM port mux; no owner leaves the RAM fully idle.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    if (w_host_own) begin
      ram_en   = 1'b1;
      ram_we   = host_we;
      ram_addr = host_addr;
      ram_wd   = host_wd;
    end else if (w_cpu_own) begin
      ram_en   = 1'b1;
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_wd   = cpu_wd;
    end
  end

  assign host_gnt    = w_host_own;
  assign cpu_stall   = !pc_rst && cpu_req && !w_cpu_own;
  assign cpu_rdata   = w_cpu_own ? ram_rd : '0;
  assign host_rvalid = r_rvalid;
  assign host_rdata  = r_rdata;

  always_ff @(posedge clk) begin
    if (pc_rst) begin
      r_state     <= ST_CPU;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (!host_req || w_host_own) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WCW'(STARVE_LIMIT)) begin
        r_wait_cnt <= r_wait_cnt + WCW'(1);
      end

      r_rvalid <= w_host_own && !host_we;
      if (w_host_own && !host_we) begin
        r_rdata <= ram_rd;
      end

      unique case (r_state)
        ST_CPU: begin
          if (w_host_own && host_lock && (BURST_MAX > 1)) begin
            r_state     <= ST_BURST;
            r_burst_cnt <= BCW'(1);
          end
        end
        ST_BURST: begin
          // The exiting cycle's grant (if any) still completes this edge.
          if (!host_req || !host_lock || w_burst_last) begin
            r_state     <= ST_CPU;
            r_burst_cnt <= '0;
          end else begin
            r_burst_cnt <= r_burst_cnt + BCW'(1);
          end
        end
        default: begin
          r_state     <= ST_CPU;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_stat_stalls;
  logic [CNT_W-1:0] r_stat_grants;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (pc_rst) begin
      r_stat_stalls <= '0;
      r_stat_grants <= '0;
    end else begin
      if (cpu_stall && (r_stat_stalls != '1)) begin
        r_stat_stalls <= r_stat_stalls + CNT_W'(1);
      end
      if (host_gnt && (r_stat_grants != '1)) begin
        r_stat_grants <= r_stat_grants + CNT_W'(1);
      end
    end
  end

  assign stat_cpu_stalls  = r_stat_stalls;
  assign stat_host_grants = r_stat_grants;
`else
  assign stat_cpu_stalls  = '0;
  assign stat_host_grants = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Vector-table bench for data_mem_arbiter with a behavioural RAM and read-data scoreboard.
module tb_data_mem_arbiter;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             pc_rst = 1'b0;
  logic             cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0]    cpu_addr = '0;
  logic [DW-1:0]    cpu_wd = '0;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_stall;
  logic             host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [AW-1:0]    host_addr = '0;
  logic [DW-1:0]    host_wd = '0;
  logic             host_gnt, host_rvalid;
  logic [DW-1:0]    host_rdata;
  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_wd;
  logic [DW-1:0]    ram_rd;
  logic [CNT_W-1:0] stat_cpu_stalls, stat_host_grants;

  always #5 clk = ~clk;

  // Single-port RAM: combinational read, synchronous write.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wd;
  assign ram_rd = mem[ram_addr[7:0]];

  data_mem_arbiter dut (
    .clk(clk), .pc_rst(pc_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wd(host_wd),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd),
    .stat_cpu_stalls(stat_cpu_stalls), .stat_host_grants(stat_host_grants)
  );

  typedef struct {
    string       name;
    logic        rst, creq, cwe;
    logic [7:0]  caddr;
    logic [31:0] cwd;
    logic        hreq, hwe, hlock;
    logic [7:0]  haddr;
    logic [31:0] hwd;
    logic        e_gnt, e_stall;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
  } rd_t;

  vec_t        vecs[$];
  rd_t         sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic        started = 1'b0;
  logic [31:0] last_rdata = '0;
  int          exp_stalls = 0;
  int          exp_grants = 0;

  function automatic vec_t mk(string n, logic rst, logic creq, logic cwe, logic [7:0] ca,
                              logic [31:0] cwd, logic hreq, logic hwe, logic hlock,
                              logic [7:0] ha, logic [31:0] hwd, logic eg, logic es);
    vec_t v;
    v.name = n; v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = ca; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.hlock = hlock; v.haddr = ha; v.hwd = hwd;
    v.e_gnt = eg; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(string n, string f, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h exp=%h", n, f, got, exp);
    end
  endtask

  // Apply one cycle: check registered results of the previous edge, then this cycle's comb outputs.
  task automatic step(vec_t v);
    rd_t         r;
    logic        cown, e_en, e_we;
    logic [31:0] e_addr, e_wd, e_crd;
    @(negedge clk);
    pc_rst = v.rst; cpu_req = v.creq; cpu_we = v.cwe;
    cpu_addr = 32'(v.caddr); cpu_wd = v.cwd;
    host_req = v.hreq; host_we = v.hwe; host_lock = v.hlock;
    host_addr = 32'(v.haddr); host_wd = v.hwd;
    #1;
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk(v.name, "host_rvalid", 32'(host_rvalid), 32'(r.v));
      chk(v.name, "host_rdata", host_rdata, r.d);
    end
    if (started) begin
      chk(v.name, "stat_cpu_stalls", 32'(stat_cpu_stalls), 32'(exp_stalls));
      chk(v.name, "stat_host_grants", 32'(stat_host_grants), 32'(exp_grants));
    end
    cown   = v.creq && !v.e_stall && !v.rst && !v.e_gnt;
    e_en   = v.e_gnt || cown;
    e_we   = v.e_gnt ? v.hwe : (cown && v.cwe);
    e_addr = v.e_gnt ? 32'(v.haddr) : (cown ? 32'(v.caddr) : 32'h0);
    e_wd   = v.e_gnt ? v.hwd : (cown ? v.cwd : 32'h0);
    e_crd  = cown ? mem[v.caddr] : 32'h0;
    chk(v.name, "host_gnt", 32'(host_gnt), 32'(v.e_gnt));
    chk(v.name, "cpu_stall", 32'(cpu_stall), 32'(v.e_stall));
    chk(v.name, "ram_en", 32'(ram_en), 32'(e_en));
    chk(v.name, "ram_we", 32'(ram_we), 32'(e_we));
    chk(v.name, "ram_addr", ram_addr, e_addr);
    chk(v.name, "ram_wd", ram_wd, e_wd);
    chk(v.name, "cpu_rdata", cpu_rdata, e_crd);
    if (v.rst) begin
      last_rdata = '0; r.v = 1'b0; exp_stalls = 0; exp_grants = 0; started = 1'b1;
    end else begin
      r.v = v.e_gnt && !v.hwe;
      if (r.v) last_rdata = mem[v.haddr];
`ifdef ARB_STATS_EN
      exp_stalls += int'(v.e_stall);
      exp_grants += int'(v.e_gnt);
`endif
    end
    r.d = last_rdata;
    sbq.push_back(r);
  endtask

  function automatic vec_t idle(string n);
    return mk(n, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endfunction

  initial begin
    vecs.push_back(mk("rst0",    1'b1, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0));
    vecs.push_back(mk("rst_req", 1'b1, 1'b1, 1'b1, 8'h10, 32'h99,       1'b1, 1'b1, 1'b0, 8'h20, 32'h77,       1'b0, 1'b0));
    vecs.push_back(mk("cpu_st",  1'b0, 1'b1, 1'b1, 8'h10, 32'h1234,     1'b0, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0));
    vecs.push_back(mk("cpu_ld",  1'b0, 1'b1, 1'b0, 8'h10, '0,           1'b0, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0));
    vecs.push_back(mk("host_wr", 1'b0, 1'b0, 1'b0, '0,    '0,           1'b1, 1'b1, 1'b0, 8'h20, 32'hABCD,     1'b1, 1'b0));
    vecs.push_back(mk("host_rd", 1'b0, 1'b0, 1'b0, '0,    '0,           1'b1, 1'b0, 1'b0, 8'h20, '0,           1'b1, 1'b0));
    vecs.push_back(idle("idle0"));
    vecs.push_back(mk("dual_cpu",  1'b0, 1'b1, 1'b1, 8'h24, 32'h1111,   1'b1, 1'b1, 1'b0, 8'h24, 32'h2222,     1'b0, 1'b0));
    vecs.push_back(mk("dual_host", 1'b0, 1'b0, 1'b0, '0,    '0,         1'b1, 1'b1, 1'b0, 8'h24, 32'h2222,     1'b1, 1'b0));
    vecs.push_back(mk("dual_ld",   1'b0, 1'b1, 1'b0, 8'h24, '0,         1'b0, 1'b0, 1'b0, '0,    '0,           1'b0, 1'b0));
    vecs.push_back(idle("idle1"));

    foreach (vecs[i]) begin
      step(vecs[i]);
      if (vecs[i].name == "idle0") chk("host_only", "rdata_const", host_rdata, 32'hABCD);
      if (vecs[i].name == "cpu_ld") chk("cpu_only", "load_const", cpu_rdata, 32'h1234);
    end
    chk("dual_write", "mem_24", mem[8'h24], 32'h2222);

    // Contention: host starves for four cycles, then wins one.
    step(mk("rst_cont", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      step(mk($sformatf("cont%0d", i), 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b0, 8'h20, '0,
              (i == 4 || i == 9), (i == 4 || i == 9)));
    end
    step(idle("idle2"));
`ifdef ARB_STATS_EN
    chk("contention", "stalls10", 32'(stat_cpu_stalls), 32'd2);
    chk("contention", "grants10", 32'(stat_host_grants), 32'd2);
`else
    chk("contention", "stalls10", 32'(stat_cpu_stalls), 32'd0);
    chk("contention", "grants10", 32'(stat_host_grants), 32'd0);
`endif

    // Locked burst: starvation win, eight grants total, then the CPU gets a cycle.
    for (int i = 0; i < 13; i++) begin
      step(mk($sformatf("burst%0d", i), 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b1, 1'b1, 8'h40,
              32'h5500 + 32'(i), (i >= 4 && i <= 11), (i >= 4 && i <= 11)));
    end
    step(idle("idle3"));
    chk("burst", "last_write", mem[8'h40], 32'h5500 + 32'd11);

    // Burst exit when host_req drops: CPU wins the following cycles.
    step(mk("drop_a", 1'b0, 1'b0, 1'b0, '0,    '0, 1'b1, 1'b0, 1'b1, 8'h40, '0, 1'b1, 1'b0));
    step(mk("drop_b", 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0, 1'b0, '0,    '0, 1'b0, 1'b0));
    step(mk("drop_c", 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b1, 8'h40, '0, 1'b0, 1'b0));
    step(idle("idle4"));

    // Burst exit when host_lock drops: that grant completes, then back to CPU rules.
    step(mk("unlk_a", 1'b0, 1'b0, 1'b0, '0,    '0, 1'b1, 1'b0, 1'b1, 8'h20, '0, 1'b1, 1'b0));
    step(mk("unlk_b", 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b0, 8'h20, '0, 1'b1, 1'b1));
    step(mk("unlk_c", 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b1, 8'h20, '0, 1'b0, 1'b0));
    step(idle("idle5"));

    // Reset on the third burst cycle aborts the burst and suppresses that read's rvalid.
    step(mk("rb_1", 1'b0, 1'b0, 1'b0, '0,    '0, 1'b1, 1'b0, 1'b1, 8'h20, '0, 1'b1, 1'b0));
    step(mk("rb_2", 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b1, 8'h20, '0, 1'b1, 1'b1));
    step(mk("rb_3", 1'b1, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b1, 8'h20, '0, 1'b0, 1'b0));
    step(mk("rb_4", 1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 1'b1, 8'h20, '0, 1'b0, 1'b0));
    step(idle("idle6"));
    step(idle("idle7"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
